// File: rtl/game_pkg.sv
// Shared game geometry and the per-slot cheese state encoding.
package game_pkg;

  localparam int JERRY_WIDTH  = 10;
  localparam int JERRY_HEIGHT = 10;
  localparam int CHEESE_WIDTH = 8;

  typedef enum logic [1:0] {
    ACTIVE,
    ARMING,
    TAKEN
  } cheese_slot_state_t;

endpackage

// File: rtl/cheese_slot_fsm.sv
// One cheese slot: overlap detect, debounce, take handshake, respawn hold-off
// and (with CHEESE_IDLE_RELOCATE_EN defined) an idle-relocation request.
module cheese_slot_fsm
  import game_pkg::*;
#(
  parameter int POS_W         = 12,
  parameter int DELAY_TICKS   = 10_000,
  parameter int RESPAWN_TICKS = 65_000_000,
  parameter int IDLE_TICKS    = 1_300_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] jerry_x,
  input  logic [POS_W-1:0] jerry_y,
  input  logic [POS_W-1:0] cheese_x,
  input  logic [POS_W-1:0] cheese_y,
  input  logic             grant,
  output logic             take_req,
  output logic             active,
  output logic             respawn_pulse,
  output logic             relocate_pulse
);

  localparam logic [POS_W:0] CW = (POS_W+1)'(CHEESE_WIDTH);
  localparam logic [POS_W:0] JW = (POS_W+1)'(JERRY_WIDTH);
  localparam logic [POS_W:0] JH = (POS_W+1)'(JERRY_HEIGHT);

  // Two 1-D spans [a, a+a_len) and [b, b+b_len) intersect; one extra bit keeps sums from wrapping
  function automatic logic span_hit(input logic [POS_W-1:0] a, input logic [POS_W:0] a_len,
                                    input logic [POS_W-1:0] b, input logic [POS_W:0] b_len);
    return ({1'b0, a} < ({1'b0, b} + b_len)) && ({1'b0, b} < ({1'b0, a} + a_len));
  endfunction

  cheese_slot_state_t state;
  logic [15:0]        dbc;
  logic [31:0]        rsp;
  logic               overlap;

  assign overlap  = span_hit(jerry_x, JW, cheese_x, CW) && span_hit(jerry_y, JH, cheese_y, CW);
  assign take_req = (state == ARMING) && overlap && (dbc >= 16'(DELAY_TICKS));

`ifdef CHEESE_IDLE_RELOCATE_EN
  logic [31:0] idle;
  logic        reloc_q;
  assign relocate_pulse = reloc_q;
`else
  // Idle timeout is not built in this configuration
  localparam int unused_idle_ticks = IDLE_TICKS;
  assign relocate_pulse = 1'b0;
`endif

  // Slot state machine: debounce, take on grant, respawn hold-off, idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACTIVE;
      dbc           <= '0;
      rsp           <= '0;
      active        <= 1'b1;
      respawn_pulse <= 1'b0;
`ifdef CHEESE_IDLE_RELOCATE_EN
      idle          <= '0;
      reloc_q       <= 1'b0;
`endif
    end else begin
      respawn_pulse <= 1'b0;
`ifdef CHEESE_IDLE_RELOCATE_EN
      reloc_q       <= 1'b0;
`endif
      case (state)
        ACTIVE: begin
          if (overlap) begin
            state <= ARMING;
            dbc   <= 16'd1;
`ifdef CHEESE_IDLE_RELOCATE_EN
            idle  <= '0;
          end else if (idle == 32'(IDLE_TICKS - 1)) begin
            reloc_q <= 1'b1;
            idle    <= '0;
          end else begin
            idle <= idle + 32'd1;
`endif
          end
        end
        ARMING: begin
          if (!overlap) begin
            state <= ACTIVE;
            dbc   <= '0;
          end else if (dbc < 16'(DELAY_TICKS)) begin
            dbc <= dbc + 16'd1;
          end else if (grant) begin
            // Losing arbitration simply holds dbc saturated until granted
            state  <= TAKEN;
            active <= 1'b0;
            rsp    <= '0;
            dbc    <= '0;
          end
        end
        TAKEN: begin
          if (rsp == 32'(RESPAWN_TICKS - 1)) begin
            state         <= ACTIVE;
            active        <= 1'b1;
            respawn_pulse <= 1'b1;
            rsp           <= '0;
            dbc           <= '0;
`ifdef CHEESE_IDLE_RELOCATE_EN
            idle          <= '0;
`endif
          end else begin
            rsp <= rsp + 32'd1;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/cheese_collector.sv
// N-slot cheese pickup tracker: per-slot FSMs, lowest-index take arbiter,
// shared pickup counter and goal pulse. Optional idle relocation is enabled
// by defining CHEESE_IDLE_RELOCATE_EN.
module cheese_collector
  import game_pkg::*;
#(
  parameter int N_SLOTS       = 4,
  parameter int POS_W         = 12,
  parameter int MAX_CHEESE    = 10,
  parameter int DELAY_TICKS   = 10_000,
  parameter int RESPAWN_TICKS = 65_000_000,
  parameter int IDLE_TICKS    = 1_300_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     game_reset,
  input  logic [POS_W-1:0]         jerry_x,
  input  logic [POS_W-1:0]         jerry_y,
  input  logic [N_SLOTS*POS_W-1:0] cheese_x,
  input  logic [N_SLOTS*POS_W-1:0] cheese_y,
  output logic [N_SLOTS-1:0]       slot_active,
  output logic [N_SLOTS-1:0]       taken_pulse,
  output logic [N_SLOTS-1:0]       respawn_pulse,
  output logic [N_SLOTS-1:0]       relocate_pulse,
  output logic [7:0]               cheese_ctr,
  output logic                     cheese_gm
);

  logic               clr;
  logic [N_SLOTS-1:0] take_req;
  logic [N_SLOTS-1:0] grant;

  assign clr = rst | game_reset;

  // Lowest-index requester wins: isolate the least significant set bit
  assign grant = take_req & (~take_req + {{(N_SLOTS-1){1'b0}}, 1'b1});

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    cheese_slot_fsm #(
      .POS_W        (POS_W),
      .DELAY_TICKS  (DELAY_TICKS),
      .RESPAWN_TICKS(RESPAWN_TICKS),
      .IDLE_TICKS   (IDLE_TICKS)
    ) u_slot (
      .clk           (clk),
      .rst           (clr),
      .jerry_x       (jerry_x),
      .jerry_y       (jerry_y),
      .cheese_x      (cheese_x[i*POS_W +: POS_W]),
      .cheese_y      (cheese_y[i*POS_W +: POS_W]),
      .grant         (grant[i]),
      .take_req      (take_req[i]),
      .active        (slot_active[i]),
      .respawn_pulse (respawn_pulse[i]),
      .relocate_pulse(relocate_pulse[i])
    );
  end

  // Take pulse, pickup counter and goal pulse, all registered with the grant
  always_ff @(posedge clk) begin
    if (clr) begin
      taken_pulse <= '0;
      cheese_ctr  <= '0;
      cheese_gm   <= 1'b0;
    end else begin
      taken_pulse <= grant;
      cheese_gm   <= 1'b0;
      if (|grant) begin
        if (cheese_ctr == 8'(MAX_CHEESE - 1)) begin
          cheese_ctr <= '0;
          cheese_gm  <= 1'b1;
        end else begin
          cheese_ctr <= cheese_ctr + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cheese_collector.sv
// Self-checking bench for cheese_collector: directed scenarios with literal
// expectations plus randomized positions against a timestamp-based model.
module tb_cheese_collector;

  localparam int N       = 2;
  localparam int PW      = 12;
  localparam int MAXC    = 3;
  localparam int DELAY   = 4;
  localparam int RESPAWN = 20;
  localparam int IDLE    = 50;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            game_reset = 1'b0;
  logic [PW-1:0]   jerry_x = '0, jerry_y = '0;
  logic [N*PW-1:0] cheese_x = '0, cheese_y = '0;
  logic [N-1:0]    slot_active, taken_pulse, respawn_pulse, relocate_pulse;
  logic [7:0]      cheese_ctr;
  logic            cheese_gm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cheese_collector #(
    .N_SLOTS(N), .POS_W(PW), .MAX_CHEESE(MAXC), .DELAY_TICKS(DELAY),
    .RESPAWN_TICKS(RESPAWN), .IDLE_TICKS(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .game_reset(game_reset),
    .jerry_x(jerry_x), .jerry_y(jerry_y), .cheese_x(cheese_x), .cheese_y(cheese_y),
    .slot_active(slot_active), .taken_pulse(taken_pulse), .respawn_pulse(respawn_pulse),
    .relocate_pulse(relocate_pulse), .cheese_ctr(cheese_ctr), .cheese_gm(cheese_gm)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot is described by: visible or hidden since cycle hide_t, the length
  // of the current uninterrupted overlap streak, and a quiet-cycle count.
  bit           vis[N];
  int           hide_t[N];
  int           streak[N];
  bit           prev_ov[N];
  int           quiet[N];
  int           takes = 0;
  int           mcyc = 0;
  logic [N-1:0] exp_active = '1, exp_taken = '0, exp_resp = '0, exp_reloc = '0;
  int           exp_ctr = 0;
  bit           exp_gm = 0;

  function automatic bit overlaps(input int s);
    int jx, jy, cx, cy;
    jx = int'(jerry_x); jy = int'(jerry_y);
    cx = int'(cheese_x[s*PW +: PW]); cy = int'(cheese_y[s*PW +: PW]);
    return (jx < cx + 8) && (cx < jx + 10) && (jy < cy + 8) && (cy < jy + 10);
  endfunction

  initial for (int i = 0; i < N; i++) begin
    vis[i] = 1; hide_t[i] = 0; streak[i] = 0; prev_ov[i] = 0; quiet[i] = 0;
  end

  always @(posedge clk) begin : model
    int w;
    bit ov;
    exp_taken = '0; exp_resp = '0; exp_reloc = '0; exp_gm = 0;
    if (rst || game_reset) begin
      for (int i = 0; i < N; i++) begin
        vis[i] = 1; streak[i] = 0; prev_ov[i] = 0; quiet[i] = 0;
      end
      takes = 0;
    end else begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        ov = overlaps(i);
        if (!vis[i]) begin
          if (mcyc - hide_t[i] == RESPAWN - 1) begin
            vis[i] = 1; exp_resp[i] = 1'b1; streak[i] = 0; prev_ov[i] = 0; quiet[i] = 0;
          end
        end else if (ov) begin
          streak[i]++; quiet[i] = 0; prev_ov[i] = 1;
          if (streak[i] >= DELAY + 1 && w < 0) w = i;
        end else begin
          streak[i] = 0;
          if (prev_ov[i]) prev_ov[i] = 0;  // cycle spent leaving the debounce
          else begin
`ifdef CHEESE_IDLE_RELOCATE_EN
            if (quiet[i] == IDLE - 1) begin
              exp_reloc[i] = 1'b1; quiet[i] = 0;
            end else quiet[i]++;
`endif
          end
        end
      end
      if (w >= 0) begin
        vis[w] = 0; hide_t[w] = mcyc + 1; streak[w] = 0; prev_ov[w] = 0;
        exp_taken[w] = 1'b1;
        takes++;
        exp_gm = (takes % MAXC == 0);
      end
    end
    exp_ctr = takes % MAXC;
    for (int i = 0; i < N; i++) exp_active[i] = vis[i];
    mcyc++;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("slot_active", 32'(slot_active), 32'(exp_active));
    check("taken_pulse", 32'(taken_pulse), 32'(exp_taken));
    check("respawn_pulse", 32'(respawn_pulse), 32'(exp_resp));
    check("relocate_pulse", 32'(relocate_pulse), 32'(exp_reloc));
    check("cheese_ctr", 32'(cheese_ctr), 32'(exp_ctr));
    check("cheese_gm", 32'(cheese_gm), 32'(exp_gm));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    game_reset = 1'b1;
    step(1);
    game_reset = 1'b0;
  endtask

  task automatic place(input int jx, input int jy, input int c0x, input int c0y,
                       input int c1x, input int c1y);
    jerry_x = PW'(jx); jerry_y = PW'(jy);
    cheese_x = {PW'(c1x), PW'(c0x)};
    cheese_y = {PW'(c1y), PW'(c0y)};
  endtask

  logic [1:0] reloc_exp;

  initial begin
`ifdef CHEESE_IDLE_RELOCATE_EN
    reloc_exp = 2'b11;
`else
    reloc_exp = 2'b00;
`endif
    place(300, 300, 500, 500, 600, 600);
    step(2);
    check("reset_active", 32'(slot_active), 32'h3);
    check("reset_ctr", 32'(cheese_ctr), 32'h0);
    check("reset_pulses", 32'({taken_pulse, respawn_pulse, relocate_pulse, cheese_gm}), 32'h0);
    rst = 1'b0;

    // Single take with exact latency and respawn timing
    do_reset();
    place(100, 100, 104, 104, 500, 500);
    step(4);
    check("s1_no_early_take", 32'(taken_pulse), 32'h0);
    step(1);
    check("s1_taken", 32'(taken_pulse), 32'h1);
    check("s1_ctr", 32'(cheese_ctr), 32'h1);
    check("s1_active", 32'(slot_active), 32'h2);
    place(300, 300, 104, 104, 500, 500);
    step(19);
    check("s1_no_early_respawn", 32'(respawn_pulse), 32'h0);
    step(1);
    check("s1_respawn", 32'(respawn_pulse), 32'h1);
    check("s1_active_back", 32'(slot_active), 32'h3);

    // Short overlap aborts the debounce and restarts from zero
    do_reset();
    place(100, 100, 104, 104, 500, 500);
    step(3);
    place(300, 300, 104, 104, 500, 500);
    step(6);
    check("s2_ctr", 32'(cheese_ctr), 32'h0);
    check("s2_active", 32'(slot_active), 32'h3);
    place(100, 100, 104, 104, 500, 500);
    step(4);
    check("s2_restart_wait", 32'(taken_pulse), 32'h0);
    step(1);
    check("s2_restart_take", 32'(taken_pulse), 32'h1);

    // Two simultaneous requesters, then the goal wrap on the third take
    do_reset();
    place(100, 100, 104, 104, 104, 104);
    step(5);
    check("s3_take0", 32'(taken_pulse), 32'h1);
    check("s3_ctr1", 32'(cheese_ctr), 32'h1);
    step(1);
    check("s3_take1", 32'(taken_pulse), 32'h2);
    check("s3_ctr2", 32'(cheese_ctr), 32'h2);
    check("s3_active", 32'(slot_active), 32'h0);
    step(24);
    check("s4_take_goal", 32'(taken_pulse), 32'h1);
    check("s4_gm", 32'(cheese_gm), 32'h1);
    check("s4_ctr_wrap", 32'(cheese_ctr), 32'h0);
    step(1);
    check("s4_gm_drop", 32'(cheese_gm), 32'h0);
    check("s4_ctr_after", 32'(cheese_ctr), 32'h1);

    // Idle relocation timing
    do_reset();
    place(300, 300, 104, 104, 500, 500);
    step(49);
    check("s5_no_early_reloc", 32'(relocate_pulse), 32'h0);
    step(1);
    check("s5_reloc_50", 32'(relocate_pulse), 32'(reloc_exp));
    step(49);
    check("s5_quiet_between", 32'(relocate_pulse), 32'h0);
    step(1);
    check("s5_reloc_100", 32'(relocate_pulse), 32'(reloc_exp));

    // game_reset while slots are hidden
    do_reset();
    place(100, 100, 104, 104, 104, 104);
    step(6);
    check("s6_ctr_pre", 32'(cheese_ctr), 32'h2);
    step(3);
    game_reset = 1'b1;
    step(1);
    game_reset = 1'b0;
    check("s6_active", 32'(slot_active), 32'h3);
    check("s6_ctr", 32'(cheese_ctr), 32'h0);
    check("s6_pulses", 32'({taken_pulse, respawn_pulse, relocate_pulse, cheese_gm}), 32'h0);

    // Randomized positions near each other, checked by the model every cycle
    for (int seg = 0; seg < 300; seg++) begin
      int jx, jy;
      jx = 100 + int'($urandom_range(0, 20));
      jy = 100 + int'($urandom_range(0, 20));
      place(jx, jy,
            100 + int'($urandom_range(0, 24)), 100 + int'($urandom_range(0, 24)),
            100 + int'($urandom_range(0, 24)), 100 + int'($urandom_range(0, 24)));
      if ($urandom_range(0, 9) == 0) place(400, 400, 104, 104, 110, 110);
      game_reset = ($urandom_range(0, 59) == 0);
      step(1);
      game_reset = 1'b0;
      step(int'($urandom_range(0, 11)));
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
